// File: rtl/layer5_pkg.sv
// Shared widths and arithmetic helpers for the layer-5 group-2 bias/ReLU accumulator.
package layer5_pkg;

  localparam int N_LANES = 8;
  localparam int IN_W    = 18;
  localparam int OUT_W   = 16;
  localparam int N_PASS  = 4;
  localparam int SHIFT   = 2;
  // One guard bit above the pass growth keeps acc overflow-free for any psum/bias mix.
  localparam int ACC_W   = IN_W + $clog2(N_PASS) + 1;

  function automatic logic [IN_W-1:0] lane_slice(input logic [N_LANES*IN_W-1:0] vec,
                                                 input int                        idx);
    lane_slice = vec[idx*IN_W +: IN_W];
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic [IN_W-1:0] v);
    sext = {{(ACC_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  function automatic logic [OUT_W-1:0] sat_relu(input logic signed [ACC_W-1:0] sum,
                                                input int                      shift);
    logic signed [ACC_W-1:0] r;
    r = sum >>> shift;
    if (sum[ACC_W-1]) begin
      sat_relu = {OUT_W{1'b0}};
    end else if (|r[ACC_W-1:OUT_W]) begin
      sat_relu = {OUT_W{1'b1}};
    end else begin
      sat_relu = r[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bias_relu_accum_layer5_2_lane.sv
// One output-channel lane: pass accumulator with bias folded into the first pass,
// and a registered ReLU/shift/saturate result.
module bias_relu_lane
  import layer5_pkg::*;
#(
  parameter int RSHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             first,
  input  logic             last,
  input  logic [IN_W-1:0]  psum,
  input  logic [IN_W-1:0]  bias,
  output logic [OUT_W-1:0] act
);

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] base_s;
  logic signed [ACC_W-1:0] sum_s;
  logic [OUT_W-1:0]        act_r;

  // Running sum including this cycle's psum; the first pass restarts from the bias.
  always_comb begin
    base_s = acc_r;
    if (first) begin
      base_s = sext(bias);
    end else begin
      base_s = acc_r;
    end
    sum_s = base_s + sext(psum);
  end

  // Accumulator register, emptied on abort and after the pixel's last pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (in_valid) begin
      if (last) begin
        acc_r <= {ACC_W{1'b0}};
      end else begin
        acc_r <= sum_s;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  // Output activation, updated only by a completed (non-aborted) last pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r <= {OUT_W{1'b0}};
    end else if (clr) begin
      act_r <= act_r;
    end else if (in_valid && last) begin
      act_r <= sat_relu(sum_s, RSHIFT);
    end else begin
      act_r <= act_r;
    end
  end

  assign act = act_r;

endmodule

// File: rtl/bias_relu_accum_layer5_2.sv
// Layer-5 group-2 post-adder-tree stage: shared pass sequencing and valid pulse
// around N_adder_tree independent bias/ReLU accumulator lanes.
module bias_relu_accum_layer5_2
  import layer5_pkg::*;
#(
  parameter int N_adder_tree = N_LANES,
  parameter int IN_W         = layer5_pkg::IN_W,
  parameter int N_PASS       = layer5_pkg::N_PASS,
  parameter int SHIFT        = layer5_pkg::SHIFT,
  parameter int OUT_W        = layer5_pkg::OUT_W,
  localparam int PW          = (N_PASS > 1) ? $clog2(N_PASS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [N_adder_tree*IN_W-1:0]  psum,
  input  logic [N_adder_tree*IN_W-1:0]  bias,
  output logic                      out_valid,
  output logic [N_adder_tree*OUT_W-1:0] act,
  output logic [PW-1:0]             pass_idx
);

  localparam logic [PW-1:0] LAST_IDX = PW'(N_PASS - 1);

  logic [PW-1:0] pass_idx_r;
  logic          out_valid_r;
  logic          first_s;
  logic          last_s;

  assign first_s = (pass_idx_r == {PW{1'b0}});
  assign last_s  = (pass_idx_r == LAST_IDX);

  // Pass counter: advances per valid pass, wraps after the last, cleared by abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_idx_r <= {PW{1'b0}};
    end else if (clr) begin
      pass_idx_r <= {PW{1'b0}};
    end else if (in_valid) begin
      if (last_s) begin
        pass_idx_r <= {PW{1'b0}};
      end else begin
        pass_idx_r <= pass_idx_r + PW'(1);
      end
    end else begin
      pass_idx_r <= pass_idx_r;
    end
  end

  // Single-cycle pixel-complete strobe, aligned with the registered act lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
    end else if (clr) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid & last_s;
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_relu_lane #(
      .RSHIFT (SHIFT)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (in_valid),
      .first    (first_s),
      .last     (last_s),
      .psum     (lane_slice(psum, i)),
      .bias     (lane_slice(bias, i)),
      .act      (act[OUT_W*i +: OUT_W])
    );
  end

  assign out_valid = out_valid_r;
  assign pass_idx  = pass_idx_r;

endmodule

// File: tb/tb_bias_relu_accum_layer5_2.sv
// Directed table-driven bench for bias_relu_accum_layer5_2 with hand-computed results.
module tb_bias_relu_accum_layer5_2;

  localparam int NL = 8;
  localparam int IW = 18;
  localparam int OW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic [NL*IW-1:0] psum;
  logic [NL*IW-1:0] bias;
  logic             out_valid;
  logic [NL*OW-1:0] act;
  logic [1:0]       pass_idx;

  always #5 clk = ~clk;

  bias_relu_accum_layer5_2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .psum      (psum),
    .bias      (bias),
    .out_valid (out_valid),
    .act       (act),
    .pass_idx  (pass_idx)
  );

  typedef struct {
    logic [NL*IW-1:0]            bias;
    logic [3:0][NL*IW-1:0]       ps;
    int                          gap;
    logic [NL*OW-1:0]            exp;
  } vec_t;

  vec_t vecs [5];
  int   n_chk = 0;
  int   n_bad = 0;

  function automatic logic [NL*IW-1:0] p18(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
    int               a [8];
    logic [NL*IW-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int i = 0; i < NL; i++) r[IW*i +: IW] = a[i][IW-1:0];
    return r;
  endfunction

  function automatic logic [NL*OW-1:0] p16(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
    int               a [8];
    logic [NL*OW-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int i = 0; i < NL; i++) r[OW*i +: OW] = a[i][OW-1:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic one_pass(input logic [NL*IW-1:0] ps);
    in_valid = 1'b1;
    psum     = ps;
    step();
    in_valid = 1'b0;
    psum     = '0;
  endtask

  task automatic run_pixel(input int k);
    bias = vecs[k].bias;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("v%0d_pass_idx%0d", k, p), 128'(pass_idx), 128'(p));
      one_pass(vecs[k].ps[p]);
      if (p == 3) begin
        chk($sformatf("v%0d_out_valid_pulse", k), 128'(out_valid), 128'd1);
        chk($sformatf("v%0d_act", k), act, vecs[k].exp);
      end else begin
        chk($sformatf("v%0d_out_valid_early%0d", k, p), 128'(out_valid), 128'd0);
      end
      for (int g = 0; g < vecs[k].gap; g++) begin
        step();
        chk($sformatf("v%0d_out_valid_gap", k), 128'(out_valid), 128'd0);
      end
    end
    if (vecs[k].gap == 0) step();
    chk($sformatf("v%0d_out_valid_single", k), 128'(out_valid), 128'd0);
    chk($sformatf("v%0d_act_hold", k), act, vecs[k].exp);
    chk($sformatf("v%0d_pass_idx_wrap", k), 128'(pass_idx), 128'd0);
  endtask

  initial begin
    // Mixed lanes: basic add, ReLU, small shift, exact-fit and saturating values.
    vecs[0].bias  = p18(5868, 0, -5888, 7, -1, 131071, 0, 0);
    vecs[0].ps[0] = p18(100, 4, 1000, 0, 0, 131071, 65535, 65536);
    vecs[0].ps[1] = p18(200, 4, 1000, 0, 0, 131071, 65535, 65536);
    vecs[0].ps[2] = p18(300, 4, 1000, 0, 0, 131071, 65535, 65536);
    vecs[0].ps[3] = p18(400, 4, 1000, 0, 1, 131071, 65535, 65540);
    vecs[0].gap   = 0;
    vecs[0].exp   = p16(1717, 4, 0, 1, 0, 65535, 65535, 65535);
    vecs[1]       = vecs[0];
    vecs[1].gap   = 3;
    vecs[2].bias  = p18(131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071);
    for (int p = 0; p < 4; p++) vecs[2].ps[p] = vecs[2].bias;
    vecs[2].gap   = 0;
    vecs[2].exp   = p16(65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535);
    vecs[3].bias  = p18(-131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072);
    for (int p = 0; p < 4; p++) vecs[3].ps[p] = vecs[3].bias;
    vecs[3].gap   = 0;
    vecs[3].exp   = '0;
    vecs[4].bias  = p18(10, 1, 2, 3, 4, 5, 6, -4);
    vecs[4].ps[0] = p18(100, 0, 0, 0, 0, 0, 0, 2);
    vecs[4].ps[1] = p18(-100, 0, 0, 0, 0, 0, 0, 2);
    vecs[4].ps[2] = p18(50, 0, 0, 0, 0, 0, 0, 2);
    vecs[4].ps[3] = p18(-50, 0, 0, 0, 0, 0, 0, 2);
    vecs[4].gap   = 1;
    vecs[4].exp   = p16(2, 0, 0, 0, 1, 1, 1, 1);

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; psum = '0; bias = '0;
    #12;
    chk("reset_act", act, 128'd0);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_pass_idx", 128'(pass_idx), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 5; k++) run_pixel(k);

    // Abort after two passes: no pulse, counter cleared, fresh pixel unaffected.
    bias = vecs[0].bias;
    one_pass(vecs[2].ps[0]);
    one_pass(vecs[2].ps[1]);
    clr = 1'b1; in_valid = 1'b1; psum = vecs[2].ps[2];
    step();
    clr = 1'b0; in_valid = 1'b0; psum = '0;
    chk("clr_mid_out_valid", 128'(out_valid), 128'd0);
    chk("clr_mid_pass_idx", 128'(pass_idx), 128'd0);
    chk("clr_mid_act_hold", act, vecs[4].exp);
    run_pixel(0);

    // Abort coinciding with the last pass: no pulse and act keeps previous pixel.
    run_pixel(4);
    bias = vecs[0].bias;
    for (int p = 0; p < 3; p++) one_pass(vecs[0].ps[p]);
    clr = 1'b1; in_valid = 1'b1; psum = vecs[0].ps[3];
    step();
    clr = 1'b0; in_valid = 1'b0; psum = '0;
    chk("clr_last_out_valid", 128'(out_valid), 128'd0);
    chk("clr_last_act_hold", act, vecs[4].exp);
    chk("clr_last_pass_idx", 128'(pass_idx), 128'd0);
    step();
    chk("clr_last_out_valid_after", 128'(out_valid), 128'd0);
    run_pixel(0);

    // Asynchronous reset between edges after pass 2.
    bias = vecs[4].bias;
    one_pass(vecs[4].ps[0]);
    one_pass(vecs[4].ps[1]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mid_act", act, 128'd0);
    chk("arst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("arst_mid_pass_idx", 128'(pass_idx), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_pixel(0);

    // Asynchronous reset while the valid pulse is high.
    bias = vecs[2].bias;
    for (int p = 0; p < 4; p++) one_pass(vecs[2].ps[p]);
    chk("arst_pulse_pre", 128'(out_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pulse_out_valid", 128'(out_valid), 128'd0);
    chk("arst_pulse_act", act, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_pixel(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
